// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle single-ported memory between fetch and data requesters.
// Define ARB_RR_EN for round-robin conflict resolution; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_grant,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_data_q, own_data_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [15:0]   cmd_addr_q, cmd_addr_d;
  logic [15:0]   cmd_wdata_q, cmd_wdata_d;
  logic [15:0]   if_rdata_q, if_rdata_d;
  logic [15:0]   d_rdata_q, d_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          pick_data;

`ifdef ARB_RR_EN
  logic last_data_q, last_data_d;

  // On conflict the requester not served most recently wins.
  always_comb begin
    pick_data = d_req;
    if (d_req && if_req) pick_data = ~last_data_q;
  end
`else
  always_comb begin
    pick_data = d_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_data_q  <= 1'b1;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
`ifdef ARB_RR_EN
      last_data_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_data_q  <= own_data_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
`ifdef ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_data_d  = own_data_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
`ifdef ARB_RR_EN
    last_data_d = last_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          own_data_d = pick_data;
          if (pick_data) begin
            cmd_addr_d  = d_addr;
            cmd_wr_d    = d_wr;
            cmd_wdata_d = d_wdata;
          end else begin
            cmd_addr_d  = if_addr;
            cmd_wr_d    = 1'b0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(LATENCY - 1);
        state_d = WAIT;
`ifdef ARB_RR_EN
        last_data_d = own_data_q;
`endif
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (own_data_q) begin
            d_valid_d = 1'b1;
            if (!cmd_wr_q) d_rdata_d = mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_grant  = (state_q == ISSUE) && !own_data_q;
  assign d_grant   = (state_q == ISSUE) && own_data_q;
  assign mem_en    = (state_q == ISSUE);
  assign mem_wr    = cmd_wr_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at LATENCY=4, one at LATENCY=1.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_wr;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_grant, if_valid, d_grant, d_valid, mem_en, mem_wr, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        if_req_b, d_req_b, d_wr_b;
  logic [15:0] if_addr_b, d_addr_b, d_wdata_b, mem_rdata_b;
  logic        if_grant_b, if_valid_b, d_grant_b, d_valid_b, mem_en_b, mem_wr_b, busy_b;
  logic [15:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b;

  int errors = 0;
  int checks = 0;

`ifdef ARB_RR_EN
  localparam int FG = 1;
  localparam int DG = 7;
`else
  localparam int FG = 7;
  localparam int DG = 1;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_grant(if_grant_b), .if_valid(if_valid_b), .if_rdata(if_rdata_b),
    .d_req(d_req_b), .d_wr(d_wr_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_grant(d_grant_b), .d_valid(d_valid_b), .d_rdata(d_rdata_b),
    .mem_en(mem_en_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic conflict_test(input int fg, input int dg);
    if_addr = 16'h0020;
    d_addr  = 16'h0030;
    d_wr    = 1'b0;
    for (int cyc = 0; cyc <= 13; cyc++) begin
      if_req    = (cyc <= fg);
      d_req     = (cyc <= dg);
      mem_rdata = (cyc == fg + 4) ? 16'h1111 : (cyc == dg + 4) ? 16'h2222 : 16'hDEAD;
      @(negedge clk);
      check("cf_if_grant", if_grant, cyc == fg);
      check("cf_d_grant", d_grant, cyc == dg);
      check("cf_if_valid", if_valid, cyc == fg + 5);
      check("cf_d_valid", d_valid, cyc == dg + 5);
      check("cf_mem_en", mem_en, (cyc == fg) || (cyc == dg));
      if (cyc == fg) begin
        check("cf_if_addr", mem_addr, 32'h0020);
        check("cf_if_wr", mem_wr, 0);
      end
      if (cyc == dg) check("cf_d_addr", mem_addr, 32'h0030);
      if (cyc == fg + 5) check("cf_if_rdata", if_rdata, 32'h1111);
      if (cyc == dg + 5) check("cf_d_rdata", d_rdata, 32'h2222);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; d_req = 0; d_wr = 0; if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    if_req_b = 0; d_req_b = 0; d_wr_b = 0; if_addr_b = '0; d_addr_b = '0; d_wdata_b = '0; mem_rdata_b = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grants", {if_grant, d_grant}, 0);
    check("rst_valids", {if_valid, d_valid}, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    check("rst_b_busy", busy_b, 0);
    next_cycle();
    rst = 1'b0;

    // Two back-to-back conflicts: expectations identical in both builds.
    conflict_test(FG, DG);
    conflict_test(FG, DG);

    // Single fetch
    if_addr = 16'h0010;
    for (int cyc = 0; cyc <= 7; cyc++) begin
      if_req    = (cyc <= 1);
      mem_rdata = (cyc == 5) ? 16'hA5A5 : 16'hDEAD;
      @(negedge clk);
      check("sf_if_grant", if_grant, cyc == 1);
      check("sf_mem_en", mem_en, cyc == 1);
      check("sf_busy", busy, (cyc >= 1) && (cyc <= 5));
      check("sf_if_valid", if_valid, cyc == 6);
      check("sf_d_side", {d_grant, d_valid}, 0);
      if (cyc == 1) begin
        check("sf_mem_addr", mem_addr, 32'h0010);
        check("sf_mem_wr", mem_wr, 0);
      end
      if (cyc >= 6) check("sf_if_rdata", if_rdata, 32'hA5A5);
      next_cycle();
    end

    // Store
    d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
    for (int cyc = 0; cyc <= 7; cyc++) begin
      d_req     = (cyc <= 1);
      mem_rdata = (cyc == 5) ? 16'h5555 : 16'hDEAD;
      @(negedge clk);
      check("st_d_grant", d_grant, cyc == 1);
      check("st_mem_en", mem_en, cyc == 1);
      check("st_d_valid", d_valid, cyc == 6);
      check("st_if_grant", if_grant, 0);
      if (cyc == 1 || cyc == 3) begin
        check("st_mem_wr", mem_wr, 1);
        check("st_mem_addr", mem_addr, 32'h0040);
        check("st_mem_wdata", mem_wdata, 32'h1234);
      end
      if (cyc >= 6) check("st_d_rdata_kept", d_rdata, 32'h2222);
      next_cycle();
    end
    d_wr = 1'b0;

    // Reset while a fetch is in WAIT
    if_addr = 16'h0050;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      if_req    = (cyc <= 1);
      rst       = (cyc == 3);
      mem_rdata = 16'h7777;
      @(negedge clk);
      check("rw_busy", busy, (cyc >= 1) && (cyc <= 3));
      check("rw_if_valid", if_valid, 0);
      if (cyc == 4) begin
        check("rw_grants", {if_grant, d_grant}, 0);
        check("rw_mem_en_wr", {mem_en, mem_wr}, 0);
        check("rw_mem_addr", mem_addr, 0);
        check("rw_mem_wdata", mem_wdata, 0);
        check("rw_if_rdata", if_rdata, 0);
        check("rw_d_rdata", d_rdata, 0);
        check("rw_d_valid", d_valid, 0);
      end
      next_cycle();
    end
    rst = 1'b0;

    // LATENCY = 1 load
    d_addr_b = 16'h0060;
    for (int cyc = 0; cyc <= 4; cyc++) begin
      d_req_b     = (cyc <= 1);
      mem_rdata_b = (cyc == 2) ? 16'hBEEF : 16'h0BAD;
      @(negedge clk);
      check("l1_d_grant", d_grant_b, cyc == 1);
      check("l1_d_valid", d_valid_b, cyc == 3);
      check("l1_busy", busy_b, (cyc >= 1) && (cyc <= 2));
      if (cyc == 1) check("l1_mem_addr", mem_addr_b, 32'h0060);
      if (cyc == 3) check("l1_d_rdata", d_rdata_b, 32'hBEEF);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
